// File: rtl/multicycle_alu.sv
// multicycle_alu: EX-stage execution unit. Single-cycle arithmetic, logic and
// branch compares; SLL/SRL iterate through a serial shifter one bit per cycle.
// Results are held on a valid/ready output until the downstream stage takes them.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | ready for a new operation (in_ready=1)
// S_SHIFT | serial shift in progress, one bit per cycle
// S_DONE  | result/bcond valid, waiting for out_ready
module multicycle_alu #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        alu_op,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic              bcond,
  output logic              busy
);

  localparam int SHW = $clog2(DATA_W);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_SLL = 4'd2;
  localparam logic [3:0] OP_XOR = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_AND = 4'd5;
  localparam logic [3:0] OP_SRL = 4'd6;
  localparam logic [3:0] OP_BEQ = 4'd7;
  localparam logic [3:0] OP_BNE = 4'd8;
  localparam logic [3:0] OP_BLT = 4'd9;
  localparam logic [3:0] OP_BGE = 4'd10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              dir_left_q, dir_left_d;
  logic [DATA_W-1:0] sreg_q, sreg_d;
  logic [SHW-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              bcond_q, bcond_d;

  logic [DATA_W-1:0] alu_res;
  logic              alu_bc;
  logic              is_shift;
  logic [SHW-1:0]    shamt;
  logic [DATA_W-1:0] shift_step;

  assign shamt = in_b[SHW-1:0];

  // Single-cycle datapath evaluated directly on the request inputs.
  always_comb begin
    alu_res  = '0;
    alu_bc   = 1'b0;
    is_shift = 1'b0;
    case (alu_op)
      OP_ADD: alu_res = in_a + in_b;
      OP_SUB: alu_res = in_a - in_b;
      OP_SLL: is_shift = 1'b1;
      OP_XOR: alu_res = in_a ^ in_b;
      OP_OR:  alu_res = in_a | in_b;
      OP_AND: alu_res = in_a & in_b;
      OP_SRL: is_shift = 1'b1;
      OP_BEQ: alu_bc = (in_a == in_b);
      OP_BNE: alu_bc = (in_a != in_b);
      OP_BLT: alu_bc = ($signed(in_a) < $signed(in_b));
      OP_BGE: alu_bc = ($signed(in_a) >= $signed(in_b));
      // Undefined codes execute as ADD.
      default: alu_res = in_a + in_b;
    endcase
  end

  // One-bit step of the serial shifter, zero fill in both directions.
  always_comb begin
    shift_step = dir_left_q ? {sreg_q[DATA_W-2:0], 1'b0}
                            : {1'b0, sreg_q[DATA_W-1:1]};
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_d    = state_q;
    dir_left_d = dir_left_q;
    sreg_d     = sreg_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
    bcond_d    = bcond_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (is_shift) begin
            dir_left_d = (alu_op == OP_SLL);
            sreg_d     = in_a;
            cnt_d      = shamt;
            if (shamt == '0) begin
              // Zero shift bypasses the shifter entirely.
              result_d = in_a;
              bcond_d  = 1'b0;
              state_d  = S_DONE;
            end else begin
              state_d = S_SHIFT;
            end
          end else begin
            result_d = alu_res;
            bcond_d  = alu_bc;
            state_d  = S_DONE;
          end
        end
      end
      S_SHIFT: begin
        sreg_d = shift_step;
        cnt_d  = cnt_q - 1'b1;
        // The final step's value goes straight to the result register.
        if (cnt_q == SHW'(1)) begin
          result_d = shift_step;
          bcond_d  = 1'b0;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      dir_left_q <= 1'b0;
      sreg_q     <= '0;
      cnt_q      <= '0;
      result_q   <= '0;
      bcond_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      dir_left_q <= dir_left_d;
      sreg_q     <= sreg_d;
      cnt_q      <= cnt_d;
      result_q   <= result_d;
      bcond_q    <= bcond_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign result    = result_q;
  assign bcond     = bcond_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// tb_multicycle_alu: directed cases plus randomized operations checked
// against a plain-arithmetic reference model.
module tb_multicycle_alu;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  alu_op = 4'd0;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        bcond;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  multicycle_alu #(.DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .bcond(bcond), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference: result, branch condition and accept-to-valid latency.
  task automatic ref_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] r, output logic bc, output int lat);
    int sh;
    sh  = int'(b % 32);
    r   = '0;
    bc  = 1'b0;
    lat = 1;
    case (op)
      4'd1:  r = a - b;
      4'd2:  begin r = a << sh; lat = sh + 1; end
      4'd3:  r = a ^ b;
      4'd4:  r = a | b;
      4'd5:  r = a & b;
      4'd6:  begin r = a >> sh; lat = sh + 1; end
      4'd7:  bc = (a == b);
      4'd8:  bc = (a != b);
      4'd9:  bc = ($signed(a) < $signed(b));
      4'd10: bc = ($signed(a) >= $signed(b));
      default: r = a + b;
    endcase
  endtask

  // Issue one operation, verify latency/outputs, hold for `hold` cycles of
  // backpressure (optionally poking a stray request), then retire it.
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int hold, input bit poke);
    logic [31:0] er;
    logic        eb;
    int          el;
    int          lat;
    ref_model(op, a, b, er, eb, el);
    chk("in_ready_idle", in_ready, 1);
    in_valid  = 1'b1;
    alu_op    = op;
    in_a      = a;
    in_b      = b;
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    alu_op   = 4'($urandom);
    in_a     = $urandom;
    in_b     = $urandom;
    lat = 1;
    while (!out_valid && lat <= 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, el);
    chk("result", result, er);
    chk("bcond", bcond, eb);
    chk("busy_done", busy, 1);
    chk("in_ready_done", in_ready, 0);
    for (int i = 0; i < hold; i++) begin
      if (poke) begin
        in_valid = 1'b1;
        alu_op   = 4'd0;
        in_a     = $urandom;
        in_b     = $urandom;
      end
      @(posedge clk); #1;
      chk("hold_valid", out_valid, 1);
      chk("hold_result", result, er);
      chk("hold_bcond", bcond, eb);
      chk("hold_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("retire_valid", out_valid, 0);
    chk("retire_in_ready", in_ready, 1);
    chk("retire_busy", busy, 0);
  endtask

  initial begin
    // Reset held with a pending request: nothing may be accepted.
    in_valid = 1'b1;
    alu_op   = 4'd0;
    in_a     = 32'd7;
    in_b     = 32'd5;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_bcond", bcond, 0);
    chk("rst_busy", busy, 0);
    in_valid = 1'b0;
    reset    = 1'b1;
    @(posedge clk); #1;

    do_op(4'd0, 32'd7, 32'd5, 0, 1'b0);
    do_op(4'd1, 32'd0, 32'd1, 0, 1'b0);
    do_op(4'd9, 32'hFFFF_FFFF, 32'd1, 0, 1'b0);
    do_op(4'd10, 32'hFFFF_FFFF, 32'd1, 0, 1'b0);
    do_op(4'd8, 32'd3, 32'd3, 0, 1'b0);
    do_op(4'd7, 32'd3, 32'd3, 0, 1'b0);
    do_op(4'd2, 32'h0000_0001, 32'h0000_0025, 0, 1'b0);
    do_op(4'd6, 32'h8000_0000, 32'd31, 0, 1'b0);
    do_op(4'd2, 32'h1234_5678, 32'd0, 0, 1'b0);
    do_op(4'd3, 32'h0000_F0F0, 32'h0000_FF00, 10, 1'b1);
    // The poked request during the hold must not have been queued.
    @(posedge clk); #1;
    chk("no_stray_accept", out_valid, 0);
    do_op(4'd13, 32'd2, 32'd3, 0, 1'b0);

    // Reset in the middle of a long shift discards it.
    in_valid = 1'b1;
    alu_op   = 4'd6;
    in_a     = 32'hDEAD_BEEF;
    in_b     = 32'd20;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    chk("mid_busy_pre", busy, 1);
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_result", result, 0);
    chk("mid_rst_bcond", bcond, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (25) @(posedge clk);
    #1;
    chk("post_rst_no_output", out_valid, 0);
    do_op(4'd5, 32'hC, 32'hA, 0, 1'b0);

    // Randomized operations.
    for (int n = 0; n < 150; n++) begin
      do_op(4'($urandom_range(0, 15)), $urandom, $urandom,
            $urandom_range(0, 3), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
